inst_buffer_nw: RTL and testbench
=================================

Name: inst_buffer_nw

Overview:
Parametrised N-wide instruction FIFO between IF and PreDecode; the next generation of the 2-in/2-out instruction buffer.
- Enqueue width, dequeue width and depth are independent parameters; DEPTH need not be a power of two.
- Consumer reports how many head entries it took (partial dequeue) instead of all-or-nothing ready.
- Adds occupancy and almost-full outputs; sparse in_valid patterns are compacted in lane order.

Parameters:
DEPTH, 16, instruction slots; DEPTH >= max(ENQ_W, DEQ_W) and >= 2
ENQ_W, 2, enqueue lanes per cycle
DEQ_W, 2, dequeue lanes per cycle
AF_MARGIN, 2, almost_full asserts when free slots < AF_MARGIN; range 0..DEPTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries
in_valid  input  ENQ_W  per-lane valid; any bit pattern legal
in_payload  input  ENQ_W*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W]
in_accept  output  1  whole enqueue bundle accepted this cycle
out_valid  output  DEQ_W  thermometer: lane j valid iff count > j
out_payload  output  DEQ_W*PAYLOAD_W  lane j = entry head+j (mod DEPTH); zero when lane invalid
out_take  input  clog2(DEQ_W+1)  number of head entries consumed this cycle
occupancy  output  clog2(DEPTH+1)  current count
almost_full  output  1  (DEPTH - count) < AF_MARGIN

Behaviour:
- PAYLOAD_W = INST_WIDTH + INST_ADDR_WIDTH + 1 + INST_ADDR_WIDTH + BP_GHR_BITS. Field order, LSB first: inst, pc, pred_taken, pred_target, pred_hist.
- Reset (rst_n low, asynchronous):
  - head = tail = count = 0.
  - out_valid = 0, out_payload = 0, occupancy = 0, almost_full = (DEPTH < AF_MARGIN).
  - Storage need not be reset.
- take = min(out_take, count, DEQ_W). Over-request is clipped and never underflows.
- in_cnt = popcount(in_valid).
- in_accept = (in_cnt <= DEPTH - count + take) && !flush. This is combinational and may depend on out_take in the same cycle.
- Enqueue is all-or-nothing: either no lane is written, or all valid lanes are written.
  - Valid lanes are written compacted, in ascending lane order, at tail, tail+1, ... (mod DEPTH).
  - Example: in_valid=2'b10 writes lane 1 at tail.
- Rejected bundle: no state change from enqueue. IF holds and retries; the buffer keeps nothing.
- Clock edge, no flush:
  - head += take (mod DEPTH).
  - tail += (in_accept ? in_cnt : 0) (mod DEPTH).
  - count += accepted in_cnt - take.
- Wrap: pointer add uses modulo DEPTH via compare-and-subtract (sum >= DEPTH -> sum - DEPTH). Correct for non-power-of-two DEPTH.
- Latency: an entry enqueued at edge n is visible on out_* after edge n. There is no same-cycle bypass, so an empty buffer never shows an input.
- Full buffer with take>0: enqueue of up to take entries is accepted in the same cycle. A slot freed by dequeue is reused by enqueue at the same edge.
- Empty buffer: out_valid = 0 and out_take is ignored.
- flush = 1 at an edge:
  - head = tail = count = 0.
  - Simultaneous enqueue and dequeue are discarded; in_accept is 0 that cycle.
  - Flush has priority over all.
- out_payload lanes with out_valid=0 are driven to zero. No X is propagated downstream.
- Assertions (sim only):
  - count <= DEPTH.
  - out_take <= DEQ_W.
  - DEPTH >= max(ENQ_W, DEQ_W).

Decomposition:
- Shared define/package:
  - PAYLOAD_W and the field offsets/widths (IBUF_INST_LSB, IBUF_PC_LSB, IBUF_PT_BIT, IBUF_TGT_LSB, IBUF_HIST_LSB).
  - pack/unpack macros used by IF and PreDecode.
- One sub-module, ibuf_lane_compact (combinational). Inputs: in_valid, tail. Outputs: per-lane write enable, per-lane write index mod DEPTH, in_cnt.
- Top module holds storage, pointers, count and output muxing.

Test Plan:
- Reset then idle, DEPTH=16, ENQ_W=2, DEQ_W=2 -> out_valid=0, occupancy=0, almost_full=0, in_accept=1 with in_valid=0.
- Enqueue pc 0x00,0x04 (in_valid=11), next cycle out_take=1 -> out_payload lane0 pc=0x00; next cycle lane0 pc=0x04, out_valid=01.
- Sparse input in_valid=10 with pc 0x40 in lane 1 -> stored at tail; next cycle out_valid=01, lane0 pc=0x40, occupancy=1.
- Fill to 16 with out_take=0 -> in_accept=0 and state unchanged. Then out_take=2 with in_valid=11 -> in_accept=1, occupancy stays 16, almost_full=1.
- DEPTH=6, ENQ_W=4, DEQ_W=3: stream 30 sequential PCs with randomized out_take 0..3 -> PCs emerge strictly in order across wrap, never more than 6 held, out_take=3 with occupancy=1 removes exactly 1.
- flush asserted with occupancy=5, in_valid=11 and out_take=2 in the same cycle -> next cycle occupancy=0, out_valid=0, and neither input lane is ever output.

Source files
------------

// File: rtl/inst_buffer_nw_pkg.sv
// Shared instruction-buffer payload layout.
// Used by IF (pack), the buffer, and PreDecode (unpack).
package inst_buffer_nw_pkg;

    localparam int INST_WIDTH      = 32;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int BP_GHR_BITS     = 8;

    localparam int PAYLOAD_W = INST_WIDTH + INST_ADDR_WIDTH + 1
                             + INST_ADDR_WIDTH + BP_GHR_BITS;

    localparam int IBUF_INST_LSB = 0;
    localparam int IBUF_PC_LSB   = IBUF_INST_LSB + INST_WIDTH;
    localparam int IBUF_PT_BIT   = IBUF_PC_LSB + INST_ADDR_WIDTH;
    localparam int IBUF_TGT_LSB  = IBUF_PT_BIT + 1;
    localparam int IBUF_HIST_LSB = IBUF_TGT_LSB + INST_ADDR_WIDTH;

    // Packed MSB-first, so inst lands at bit 0.
    typedef struct packed {
        logic [BP_GHR_BITS-1:0]     pred_hist;
        logic [INST_ADDR_WIDTH-1:0] pred_target;
        logic                       pred_taken;
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0]      inst;
    } ibuf_entry_t;

    function automatic logic [PAYLOAD_W-1:0] ibuf_pack(
        input logic [INST_WIDTH-1:0]      inst,
        input logic [INST_ADDR_WIDTH-1:0] pc,
        input logic                       pred_taken,
        input logic [INST_ADDR_WIDTH-1:0] pred_target,
        input logic [BP_GHR_BITS-1:0]     pred_hist
    );
        ibuf_entry_t e;
        e.inst        = inst;
        e.pc          = pc;
        e.pred_taken  = pred_taken;
        e.pred_target = pred_target;
        e.pred_hist   = pred_hist;
        return e;
    endfunction

    function automatic ibuf_entry_t ibuf_unpack(
        input logic [PAYLOAD_W-1:0] p
    );
        return ibuf_entry_t'(p);
    endfunction

endpackage

// File: rtl/ibuf_lane_compact.sv
// Compacts sparse enqueue lanes onto consecutive
// slots starting at tail, wrapping modulo DEPTH.
module ibuf_lane_compact #(
    parameter int DEPTH = 16,
    parameter int ENQ_W = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(ENQ_W + 1)
) (
    input  logic [ENQ_W-1:0]            in_valid,
    input  logic [PTR_W-1:0]            tail,
    output logic [ENQ_W-1:0]            lane_we,
    output logic [ENQ_W-1:0][PTR_W-1:0] lane_idx,
    output logic [CNT_W-1:0]            in_cnt
);

    localparam int SW = PTR_W + 1;

    logic [ENQ_W-1:0][SW-1:0] sum;
    logic [CNT_W-1:0]         off;

    // Each valid lane takes the slot after all lower valid lanes.
    always_comb begin
        sum      = '0;
        off      = '0;
        lane_idx = '0;
        lane_we  = in_valid;
        for (int i = 0; i < ENQ_W; i++) begin
            sum[i] = {1'b0, tail} + SW'(off);
            if (sum[i] >= SW'(DEPTH)) begin
                sum[i] = sum[i] - SW'(DEPTH);
            end
            lane_idx[i] = sum[i][PTR_W-1:0];
            off         = off + CNT_W'(in_valid[i]);
        end
        in_cnt = off;
    end

endmodule

// File: rtl/inst_buffer_nw.sv
// N-wide instruction FIFO between IF and PreDecode
// with partial dequeue, occupancy and almost-full.
module inst_buffer_nw
    import inst_buffer_nw_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_W     = 2,
    parameter int DEQ_W     = 2,
    parameter int AF_MARGIN = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [ENQ_W-1:0]               in_valid,
    input  logic [ENQ_W*PAYLOAD_W-1:0]     in_payload,
    output logic                           in_accept,
    output logic [DEQ_W-1:0]               out_valid,
    output logic [DEQ_W*PAYLOAD_W-1:0]     out_payload,
    input  logic [$clog2(DEQ_W+1)-1:0]     out_take,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic                           almost_full
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int ECNT_W = $clog2(ENQ_W + 1);
    localparam int SW     = PTR_W + 1;
    localparam int FW     = OCC_W + 1;

    logic [PAYLOAD_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [OCC_W-1:0]          count_q, count_d;
    logic [OCC_W-1:0]          take, enq_n;
    logic [ECNT_W-1:0]         in_cnt;
    logic [ENQ_W-1:0]          lane_we;
    logic [ENQ_W-1:0][PTR_W-1:0] lane_idx;
    logic [FW-1:0]             room;
    logic [SW-1:0]             head_sum, tail_sum;
    logic [DEQ_W-1:0][SW-1:0]  rd_sum;

    ibuf_lane_compact #(
        .DEPTH (DEPTH),
        .ENQ_W (ENQ_W),
        .PTR_W (PTR_W),
        .CNT_W (ECNT_W)
    ) u_compact (
        .in_valid (in_valid),
        .tail     (tail_q),
        .lane_we  (lane_we),
        .lane_idx (lane_idx),
        .in_cnt   (in_cnt)
    );

    // Clip the consumer request to what is present and to DEQ_W.
    always_comb begin
        take = OCC_W'(out_take);
        if (take > OCC_W'(DEQ_W)) take = OCC_W'(DEQ_W);
        if (take > count_q)       take = count_q;
    end

    // Whole-bundle admission; dequeued slots count as free.
    always_comb begin
        enq_n     = OCC_W'(in_cnt);
        room      = FW'(DEPTH) - FW'(count_q) + FW'(take);
        in_accept = (FW'(enq_n) <= room) && !flush;
    end

    // Pointer and count update; flush overrides everything.
    always_comb begin
        head_sum = {1'b0, head_q} + SW'(take);
        if (head_sum >= SW'(DEPTH)) head_sum = head_sum - SW'(DEPTH);
        tail_sum = {1'b0, tail_q} + (in_accept ? SW'(enq_n) : '0);
        if (tail_sum >= SW'(DEPTH)) tail_sum = tail_sum - SW'(DEPTH);
        head_d  = head_sum[PTR_W-1:0];
        tail_d  = tail_sum[PTR_W-1:0];
        count_d = count_q + (in_accept ? enq_n : '0) - take;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write; contents are qualified by count, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_W; i++) begin
            if (in_accept && lane_we[i]) begin
                mem_q[lane_idx[i]] <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Head-relative read lanes; invalid lanes forced to zero.
    always_comb begin
        rd_sum      = '0;
        out_valid   = '0;
        out_payload = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            rd_sum[j] = {1'b0, head_q} + SW'(j);
            if (rd_sum[j] >= SW'(DEPTH)) rd_sum[j] = rd_sum[j] - SW'(DEPTH);
            out_valid[j] = count_q > OCC_W'(j);
            if (out_valid[j]) begin
                out_payload[j*PAYLOAD_W +: PAYLOAD_W] = mem_q[rd_sum[j][PTR_W-1:0]];
            end
        end
    end

    assign occupancy   = count_q;
    assign almost_full = (FW'(DEPTH) - FW'(count_q)) < FW'(AF_MARGIN);

`ifndef SYNTHESIS
    a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= OCC_W'(DEPTH));
    a_take_max : assert property (@(posedge clk) disable iff (!rst_n)
        out_take <= ($clog2(DEQ_W+1))'(DEQ_W));
    a_depth_min : assert property (@(posedge clk)
        (DEPTH >= ENQ_W) && (DEPTH >= DEQ_W) && (DEPTH >= 2));
`endif

endmodule

// File: tb/tb_inst_buffer_nw.sv
// Directed bench for inst_buffer_nw: 16x2x2 and 6x4x3 builds.
// Checks reset, order, sparse, full, wrap and flush.
module tb_inst_buffer_nw;
    import inst_buffer_nw_pkg::*;

    localparam int PW = PAYLOAD_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            a_flush;
    logic [1:0]      a_in_valid;
    logic [2*PW-1:0] a_in_payload;
    logic            a_in_accept;
    logic [1:0]      a_out_valid;
    logic [2*PW-1:0] a_out_payload;
    logic [1:0]      a_out_take;
    logic [4:0]      a_occ;
    logic            a_af;

    logic            b_flush;
    logic [3:0]      b_in_valid;
    logic [4*PW-1:0] b_in_payload;
    logic            b_in_accept;
    logic [2:0]      b_out_valid;
    logic [3*PW-1:0] b_out_payload;
    logic [1:0]      b_out_take;
    logic [2:0]      b_occ;
    logic            b_af;

    inst_buffer_nw #(.DEPTH(16), .ENQ_W(2), .DEQ_W(2), .AF_MARGIN(2)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_payload(a_in_payload),
        .in_accept(a_in_accept), .out_valid(a_out_valid),
        .out_payload(a_out_payload), .out_take(a_out_take),
        .occupancy(a_occ), .almost_full(a_af)
    );

    inst_buffer_nw #(.DEPTH(6), .ENQ_W(4), .DEQ_W(3), .AF_MARGIN(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_payload(b_in_payload),
        .in_accept(b_in_accept), .out_valid(b_out_valid),
        .out_payload(b_out_payload), .out_take(b_out_take),
        .occupancy(b_occ), .almost_full(b_af)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [31:0] pc);
        return ibuf_pack(pc ^ 32'h1357_0000, pc, pc[2], pc + 32'h10, pc[9:2]);
    endfunction

    function automatic logic [PW-1:0] a_lane(input int j);
        return a_out_payload[j*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] b_lane(input int j);
        return b_out_payload[j*PW +: PW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [3:0]  v, vv;
        int next_k, lane_k, cyc, ot, cnt, tk, ncnt;
        logic acc;

        a_flush = 0; a_in_valid = 0; a_in_payload = '0; a_out_take = 0;
        b_flush = 0; b_in_valid = 0; b_in_payload = '0; b_out_take = 0;

        // asynchronous reset, before any clock edge
        #2;
        chk("a_rst_occ", a_occ, 0);
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_lane0", a_lane(0), 0);
        chk("a_rst_af", a_af, 0);
        chk("b_rst_af", b_af, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("a_idle_valid", a_out_valid, 0);
        chk("a_idle_occ", a_occ, 0);
        chk("a_idle_af", a_af, 0);
        chk("a_idle_acc", a_in_accept, 1);

        // pair enqueue, then single takes
        a_in_valid = 2'b11;
        a_in_payload = {mk(32'h04), mk(32'h00)};
        #1;
        chk("a_pair_acc", a_in_accept, 1);
        chk("a_nobypass", a_out_valid, 0);
        tick();
        a_in_valid = 0; a_out_take = 1;
        #1;
        chk("a_pair_valid", a_out_valid, 2'b11);
        chk("a_pair_l0", a_lane(0), mk(32'h00));
        chk("a_pair_l1", a_lane(1), mk(32'h04));
        chk("a_pair_occ", a_occ, 2);
        tick();
        a_out_take = 0;
        #1;
        chk("a_take1_valid", a_out_valid, 2'b01);
        chk("a_take1_l0", a_lane(0), mk(32'h04));
        chk("a_take1_l1", a_lane(1), 0);
        chk("a_take1_occ", a_occ, 1);
        a_out_take = 1;
        tick();
        a_out_take = 0;
        #1;
        chk("a_drain_occ", a_occ, 0);
        chk("a_drain_valid", a_out_valid, 0);

        // sparse lane 1 only
        a_in_valid = 2'b10;
        a_in_payload = {mk(32'h40), mk(32'h99)};
        tick();
        a_in_valid = 0;
        #1;
        chk("a_sparse_valid", a_out_valid, 2'b01);
        chk("a_sparse_l0", a_lane(0), mk(32'h40));
        chk("a_sparse_occ", a_occ, 1);

        // fill to 16
        for (int k = 0; k < 7; k++) begin
            a_in_valid = 2'b11;
            a_in_payload = {mk(32'h100 + 8*k + 4), mk(32'h100 + 8*k)};
            tick();
        end
        a_in_valid = 2'b01;
        a_in_payload = {mk(32'hBAD), mk(32'h138)};
        tick();
        a_in_valid = 0;
        #1;
        chk("a_full_occ", a_occ, 16);
        chk("a_full_af", a_af, 1);
        chk("a_full_l0", a_lane(0), mk(32'h40));
        chk("a_full_l1", a_lane(1), mk(32'h100));
        a_in_valid = 2'b11;
        a_in_payload = {mk(32'h204), mk(32'h200)};
        #1;
        chk("a_full_reject", a_in_accept, 0);
        tick();
        chk("a_rej_occ", a_occ, 16);
        chk("a_rej_l0", a_lane(0), mk(32'h40));
        chk("a_rej_l1", a_lane(1), mk(32'h100));
        a_out_take = 2;
        #1;
        chk("a_full_swap_acc", a_in_accept, 1);
        tick();
        a_in_valid = 0; a_out_take = 0;
        #1;
        chk("a_swap_occ", a_occ, 16);
        chk("a_swap_af", a_af, 1);
        chk("a_swap_l0", a_lane(0), mk(32'h104));
        chk("a_swap_l1", a_lane(1), mk(32'h108));

        // drain across the wrap
        for (int i = 0; i < 8; i++) begin
            a_out_take = 2;
            #1;
            chk("a_dr_occ", a_occ, 16 - 2*i);
            chk("a_dr_af", a_af, (i == 0) ? 1 : 0);
            chk("a_dr_l0", a_lane(0),
                (i < 7) ? mk(32'h100 + 4*(1 + 2*i)) : mk(32'h200));
            chk("a_dr_l1", a_lane(1),
                (i < 7) ? mk(32'h100 + 4*(2 + 2*i)) : mk(32'h204));
            tick();
        end
        a_out_take = 0;
        #1;
        chk("a_dr_end_occ", a_occ, 0);
        chk("a_dr_end_valid", a_out_valid, 0);

        // take on empty is ignored
        a_out_take = 2;
        tick();
        a_out_take = 0;
        #1;
        chk("a_empty_take", a_occ, 0);

        // flush with occupancy 5 and simultaneous enq/deq
        for (int k = 0; k < 2; k++) begin
            a_in_valid = 2'b11;
            a_in_payload = {mk(32'h300 + 8*k + 4), mk(32'h300 + 8*k)};
            tick();
        end
        a_in_valid = 2'b01;
        a_in_payload = {mk(32'hBAD), mk(32'h310)};
        tick();
        a_in_valid = 0;
        #1;
        chk("a_pre_flush_occ", a_occ, 5);
        a_flush = 1; a_in_valid = 2'b11; a_out_take = 2;
        a_in_payload = {mk(32'hDEAD4), mk(32'hDEAD0)};
        #1;
        chk("a_flush_acc", a_in_accept, 0);
        tick();
        a_flush = 0; a_in_valid = 0; a_out_take = 0;
        #1;
        chk("a_flush_occ", a_occ, 0);
        chk("a_flush_valid", a_out_valid, 0);
        chk("a_flush_l0", a_lane(0), 0);
        chk("a_flush_l1", a_lane(1), 0);
        a_in_valid = 2'b01;
        a_in_payload = {mk(32'hBAD), mk(32'h500)};
        #1;
        chk("a_post_flush_nobyp", a_out_valid, 0);
        tick();
        a_in_valid = 0;
        #1;
        chk("a_post_flush_valid", a_out_valid, 2'b01);
        chk("a_post_flush_l0", a_lane(0), mk(32'h500));
        chk("a_post_flush_l1", a_lane(1), 0);
        chk("a_post_flush_occ", a_occ, 1);

        // 6-deep, 4-in, 3-out stream of 30 PCs
        next_k = 0;
        cyc = 0;
        while ((next_k < 30 || q.size() != 0) && cyc < 400) begin
            v = 4'($urandom_range(0, 15));
            ot = $urandom_range(0, 3);
            vv = '0;
            lane_k = next_k;
            for (int i = 0; i < 4; i++) begin
                if (v[i] && lane_k < 30) begin
                    vv[i] = 1'b1;
                    b_in_payload[i*PW +: PW] = mk(32'h1000 + 4*lane_k);
                    lane_k++;
                end else begin
                    b_in_payload[i*PW +: PW] = mk(32'hBAD0_0000 + i);
                end
            end
            b_in_valid = vv;
            b_out_take = 2'(ot);
            #1;
            cnt = q.size();
            tk = (ot < cnt) ? ot : cnt;
            ncnt = lane_k - next_k;
            acc = (ncnt <= 6 - cnt + tk);
            chk("b_acc", b_in_accept, acc);
            chk("b_occ", b_occ, cnt);
            chk("b_occ_max", (b_occ <= 3'd6), 1);
            for (int j = 0; j < 3; j++) begin
                chk("b_valid", b_out_valid[j], (j < cnt) ? 1 : 0);
                chk("b_lane", b_lane(j), (j < cnt) ? mk(q[j]) : '0);
            end
            @(posedge clk);
            #1;
            for (int t = 0; t < tk; t++) void'(q.pop_front());
            if (acc) begin
                for (int k = next_k; k < lane_k; k++) q.push_back(32'h1000 + 4*k);
                next_k = lane_k;
            end
            cyc++;
        end
        chk("b_stream_done", (next_k == 30 && q.size() == 0), 1);
        b_in_valid = 0; b_out_take = 0;
        #1;
        chk("b_stream_empty", b_occ, 0);

        // over-request with a single entry removes exactly one
        b_in_valid = 4'b0100;
        b_in_payload = '0;
        b_in_payload[2*PW +: PW] = mk(32'h800);
        tick();
        b_in_valid = 0;
        tick();
        b_in_valid = 4'b0001;
        b_in_payload[0 +: PW] = mk(32'h804);
        b_out_take = 3;
        #1;
        chk("b_one_valid", b_out_valid, 3'b001);
        chk("b_one_l0", b_lane(0), mk(32'h800));
        chk("b_one_l1", b_lane(1), 0);
        chk("b_one_acc", b_in_accept, 1);
        tick();
        b_in_valid = 0; b_out_take = 0;
        #1;
        chk("b_one_occ", b_occ, 1);
        chk("b_one_next", b_lane(0), mk(32'h804));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
